// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel, window and gradient types for the Sobel stage.
// Helpers widen pixels into the signed gradient domain and take magnitudes.
package sobel_pkg;

   typedef logic [7:0]         pixel_t;
   typedef pixel_t [0:8]       window_t;
   typedef logic signed [10:0] grad_t;
   typedef logic [10:0]        mag_t;

   localparam pixel_t PIX_MAX = 8'd255;

   function automatic grad_t widen(input pixel_t p);
      return grad_t'({3'b000, p});
   endfunction

   function automatic mag_t abs_grad(input grad_t g);
      return g[10] ? mag_t'(-g) : mag_t'(g);
   endfunction

endpackage

// File: rtl/sobel_kernel.sv
// sobel_kernel: combinational horizontal/vertical Sobel gradients of a 3x3 window.
// The centre pixel carries zero weight in both kernels.
module sobel_kernel
   import sobel_pkg::*;
(
   input  window_t win,
   output grad_t   gx,
   output grad_t   gy
);

   grad_t gx_pos, gx_neg, gy_pos, gy_neg;
   logic  unused_center;

   assign gx_pos = widen(win[2]) + (widen(win[5]) <<< 1) + widen(win[8]);
   assign gx_neg = widen(win[0]) + (widen(win[3]) <<< 1) + widen(win[6]);
   assign gy_pos = widen(win[6]) + (widen(win[7]) <<< 1) + widen(win[8]);
   assign gy_neg = widen(win[0]) + (widen(win[1]) <<< 1) + widen(win[2]);

   assign gx = gx_pos - gx_neg;
   assign gy = gy_pos - gy_neg;

   assign unused_center = ^win[4];

endmodule

// File: rtl/sobel_gradient.sv
// sobel_gradient: 3-stage Sobel edge pipeline with valid/ready flow and frame count.
// Define SOBEL_THRESHOLD_EN to binarise the output against THRESHOLD.
module sobel_gradient
   import sobel_pkg::*;
#(
   parameter int     OUT_PIXELS = 16,
   parameter pixel_t THRESHOLD  = 8'd128
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    win_valid,
   input  window_t window_in,
   output logic    win_ready,
   output pixel_t  pixel_out,
   output logic    pixel_valid,
   input  logic    pixel_ready,
   output logic    frame_done
);

   localparam int            CW   = $clog2(OUT_PIXELS + 1);
   localparam logic [CW-1:0] LAST = CW'(OUT_PIXELS - 1);

   grad_t         gx_c, gy_c;
   grad_t         gx_q, gy_q;
   mag_t          mag_q;
   pixel_t        pix_c;
   logic          v1, v2;
   logic          ld1, ld2, ld3;
   logic          xfer;
   logic [CW-1:0] cnt;

   sobel_kernel u_kernel (
      .win (window_in),
      .gx  (gx_c),
      .gy  (gy_c)
   );

   assign ld3       = !pixel_valid || pixel_ready;
   assign ld2       = !v2 || ld3;
   assign ld1       = !v1 || ld2;
   assign win_ready = ld1;
   assign xfer      = pixel_valid && pixel_ready;

   // S1: capture gradients of an accepted window
   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         gx_q <= '0;
         gy_q <= '0;
      end else if (ld1) begin
         v1 <= win_valid;
         if (win_valid) begin
            gx_q <= gx_c;
            gy_q <= gy_c;
         end
      end
   end

   // S2: L1 magnitude of the gradient pair
   always_ff @(posedge clk) begin
      if (rst) begin
         v2    <= 1'b0;
         mag_q <= '0;
      end else if (ld2) begin
         v2 <= v1;
         if (v1) begin
            mag_q <= abs_grad(gx_q) + abs_grad(gy_q);
         end
      end
   end

   // Output pixel mapping from the magnitude
   always_comb begin
      pix_c = '0;
`ifdef SOBEL_THRESHOLD_EN
      pix_c = (mag_q >= mag_t'(THRESHOLD)) ? PIX_MAX : 8'd0;
`else
      pix_c = (mag_q > mag_t'(PIX_MAX)) ? PIX_MAX : mag_q[7:0];
`endif
   end

`ifndef SOBEL_THRESHOLD_EN
   logic thr_unused;
   assign thr_unused = ^THRESHOLD;
`endif

   // S3: registered output, held while downstream stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_valid <= 1'b0;
         pixel_out   <= '0;
      end else if (ld3) begin
         pixel_valid <= v2;
         if (v2) begin
            pixel_out <= pix_c;
         end
      end
   end

   // Count transfers and pulse on the last pixel of each frame
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (xfer) begin
            if (cnt == LAST) begin
               cnt        <= '0;
               frame_done <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient: directed checks of latency, values, backpressure,
// frame pulses and mid-frame reset for sobel_gradient (OUT_PIXELS=4).
module tb_sobel_gradient;
   import sobel_pkg::*;

   logic    clk = 1'b0;
   logic    rst;
   logic    win_valid;
   window_t window_in;
   logic    win_ready;
   pixel_t  pixel_out;
   logic    pixel_valid;
   logic    pixel_ready;
   logic    frame_done;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   sobel_gradient #(
      .OUT_PIXELS (4),
      .THRESHOLD  (8'd128)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .win_valid   (win_valid),
      .window_in   (window_in),
      .win_ready   (win_ready),
      .pixel_out   (pixel_out),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .frame_done  (frame_done)
   );

   function automatic window_t make_win(input int id);
      window_t w;
      w = '0;
      case (id)
         0: for (int i = 0; i < 9; i++) w[i] = 8'd10;
         1: w[2] = 8'd10;
         2: begin
            w[1] = 8'd50;  w[4] = 8'd50;  w[7] = 8'd50;
            w[2] = 8'd100; w[5] = 8'd100; w[8] = 8'd100;
         end
         3: w[8] = 8'd30;
         4: w[1] = 8'd50;
         5: w[3] = 8'd70;
         6: begin w[7] = 8'd20; w[5] = 8'd25; end
         7: w[0] = 8'd60;
         default: ;
      endcase
      return w;
   endfunction

   function automatic pixel_t exp_pix(input int id);
`ifdef SOBEL_THRESHOLD_EN
      case (id)
         2, 5:    return 8'd255;
         default: return 8'd0;
      endcase
`else
      case (id)
         0: return 8'd0;
         1: return 8'd20;
         2: return 8'd255;
         3: return 8'd60;
         4: return 8'd100;
         5: return 8'd140;
         6: return 8'd90;
         7: return 8'd120;
         default: return 8'd0;
      endcase
`endif
   endfunction

   task automatic do_reset;
      rst = 1'b1;
      win_valid = 1'b0;
      pixel_ready = 1'b0;
      window_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      #1;
      checks++;
      if (pixel_valid !== 1'b0) begin
         fails++; $display("FAIL rst_valid got %b want 0", pixel_valid);
      end
      checks++;
      if (pixel_out !== 8'd0) begin
         fails++; $display("FAIL rst_pixel got %0d want 0", pixel_out);
      end
      checks++;
      if (frame_done !== 1'b0) begin
         fails++; $display("FAIL rst_frame_done got %b want 0", frame_done);
      end
      checks++;
      if (win_ready !== 1'b1) begin
         fails++; $display("FAIL rst_win_ready got %b want 1", win_ready);
      end
   endtask

   task automatic test_latency;
      int ids[3] = '{0, 1, 2};
      foreach (ids[k]) begin
         pixel_ready = 1'b1;
         win_valid = 1'b1;
         window_in = make_win(ids[k]);
         #1;
         checks++;
         if (win_ready !== 1'b1) begin
            fails++; $display("FAIL lat_accept id=%0d got %b want 1", ids[k], win_ready);
         end
         @(posedge clk); #1 win_valid = 1'b0;
         for (int e = 2; e <= 3; e++) begin
            if (e == 3) begin
               checks++;
               if (pixel_valid !== 1'b0) begin
                  fails++; $display("FAIL lat_early id=%0d got %b want 0", ids[k], pixel_valid);
               end
            end
            @(posedge clk); #1;
         end
         checks++;
         if (pixel_valid !== 1'b1) begin
            fails++; $display("FAIL lat_valid id=%0d got %b want 1", ids[k], pixel_valid);
         end
         checks++;
         if (pixel_out !== exp_pix(ids[k])) begin
            fails++;
            $display("FAIL lat_pixel id=%0d got %0d want %0d", ids[k], pixel_out, exp_pix(ids[k]));
         end
         @(posedge clk); #1;
         checks++;
         if (pixel_valid !== 1'b0) begin
            fails++; $display("FAIL lat_drain id=%0d got %b want 0", ids[k], pixel_valid);
         end
      end
   endtask

   task automatic test_back_to_back;
      int   ids[5] = '{3, 4, 5, 6, 7};
      int   sent = 0;
      int   got = 0;
      logic xf;
      logic fd_exp;
      do_reset;
      for (int c = 0; c < 100 && got < 5; c++) begin
         win_valid = (sent < 5);
         window_in = make_win(ids[sent < 5 ? sent : 4]);
         pixel_ready = !(c >= 4 && c < 8);
         #1;
         if (c >= 4 && c < 8) begin
            checks++;
            if (win_ready !== 1'b0) begin
               fails++; $display("FAIL b2b_stall_ready c=%0d got %b want 0", c, win_ready);
            end
         end
         xf = pixel_valid && pixel_ready;
         if (xf) begin
            checks++;
            if (pixel_out !== exp_pix(ids[got])) begin
               fails++;
               $display("FAIL b2b_pixel n=%0d got %0d want %0d", got, pixel_out, exp_pix(ids[got]));
            end
            got++;
         end
         if (win_valid && win_ready) sent++;
         @(posedge clk); #1;
         fd_exp = xf && (got % 4 == 0);
         checks++;
         if (frame_done !== fd_exp) begin
            fails++; $display("FAIL b2b_frame_done c=%0d got %b want %b", c, frame_done, fd_exp);
         end
      end
      checks++;
      if (got != 5) begin
         fails++; $display("FAIL b2b_timeout got %0d want 5 outputs", got);
      end
      win_valid = 1'b0;
      pixel_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (pixel_valid !== 1'b0) begin
         fails++; $display("FAIL b2b_extra got %b want 0", pixel_valid);
      end
   endtask

   task automatic test_frame;
      int   sent = 0;
      int   got = 0;
      int   pulses = 0;
      logic xf;
      logic fd_exp;
      do_reset;
      for (int c = 0; c < 100 && got < 9; c++) begin
         win_valid = (sent < 9);
         window_in = make_win(sent % 8);
         pixel_ready = 1'b1;
         #1;
         xf = pixel_valid && pixel_ready;
         if (xf) begin
            checks++;
            if (pixel_out !== exp_pix(got % 8)) begin
               fails++;
               $display("FAIL frame_pixel n=%0d got %0d want %0d", got, pixel_out, exp_pix(got % 8));
            end
            got++;
         end
         if (win_valid && win_ready) sent++;
         @(posedge clk); #1;
         fd_exp = xf && (got == 4 || got == 8);
         if (frame_done) pulses++;
         checks++;
         if (frame_done !== fd_exp) begin
            fails++; $display("FAIL frame_done c=%0d got %b want %b", c, frame_done, fd_exp);
         end
      end
      win_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (frame_done) pulses++;
      end
      checks++;
      if (got != 9 || pulses != 2) begin
         fails++; $display("FAIL frame_count outputs %0d pulses %0d want 9 and 2", got, pulses);
      end
   endtask

   task automatic test_reset_midframe;
      int   ids[4] = '{4, 5, 6, 7};
      int   got = 0;
      int   sent = 0;
      logic xf;
      logic fd_exp;
      do_reset;
      pixel_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         win_valid = 1'b1;
         window_in = make_win(k);
         @(posedge clk); #1;
      end
      win_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      pixel_ready = 1'b0;
      win_valid = 1'b1;
      window_in = make_win(3);
      @(posedge clk); #1;
      window_in = make_win(5);
      @(posedge clk); #1;
      win_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (pixel_valid !== 1'b0) begin
         fails++; $display("FAIL mid_rst_valid got %b want 0", pixel_valid);
      end
      checks++;
      if (frame_done !== 1'b0) begin
         fails++; $display("FAIL mid_rst_frame_done got %b want 0", frame_done);
      end
      checks++;
      if (win_ready !== 1'b1) begin
         fails++; $display("FAIL mid_rst_win_ready got %b want 1", win_ready);
      end
      for (int c = 0; c < 100 && got < 4; c++) begin
         win_valid = (sent < 4);
         window_in = make_win(ids[sent < 4 ? sent : 3]);
         pixel_ready = 1'b1;
         #1;
         xf = pixel_valid && pixel_ready;
         if (xf) begin
            checks++;
            if (pixel_out !== exp_pix(ids[got])) begin
               fails++;
               $display("FAIL mid_pixel n=%0d got %0d want %0d", got, pixel_out, exp_pix(ids[got]));
            end
            got++;
         end
         if (win_valid && win_ready) sent++;
         @(posedge clk); #1;
         fd_exp = xf && (got == 4);
         checks++;
         if (frame_done !== fd_exp) begin
            fails++; $display("FAIL mid_frame_done c=%0d got %b want %b", c, frame_done, fd_exp);
         end
      end
      checks++;
      if (got != 4) begin
         fails++; $display("FAIL mid_timeout got %0d want 4 outputs", got);
      end
      win_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (pixel_valid !== 1'b0) begin
         fails++; $display("FAIL mid_extra got %b want 0", pixel_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_latency;
      test_back_to_back;
      test_frame;
      test_reset_midframe;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
